// File: rtl/dynamic_input_port_para.sv
// -----------------------------------------------------------------------------
// dynamic_input_port_para
//
// Input side of a two-output-port dynamic network node. Incoming flits are
// buffered in a credit-managed FIFO. Each packet header is decoded into a
// one-hot route request: port 0 is the local port and port 1 is pass-through.
// The request is held for the whole packet and the last flit is flagged as the
// tail. One credit (yummy) goes back upstream for every flit that the
// output-port arbiters consume.
//
// Ports
//   clk             : clock
//   reset           : synchronous, active-high reset
//   my_addr         : this node's address (static after reset)
//   data_in         : flit from the upstream link
//   valid_in        : data_in carries a flit
//   thanks_0_in     : output port 0 consumed the head flit
//   thanks_1_in     : output port 1 consumed the head flit
//   data_out        : FIFO head flit
//   valid_out       : FIFO is non-empty
//   route_req_0_out : head packet requests port 0 (local)
//   route_req_1_out : head packet requests port 1 (pass-through)
//   tail_out        : head flit is the last flit of its packet
//   yummy_out       : one credit returned upstream
//   overflow_err    : sticky; a flit arrived while full and nothing popped
// -----------------------------------------------------------------------------
module dynamic_input_port_para #(
  parameter int DATA_WIDTH  = 64,
  parameter int FIFO_DEPTH  = 4,
  parameter int LEN_LSB     = 22,
  parameter int PAYLOAD_LEN = 8,
  parameter int DEST_LSB    = 30,
  parameter int DEST_WIDTH  = 22
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DEST_WIDTH-1:0] my_addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  thanks_0_in,
  input  logic                  thanks_1_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  output logic                  route_req_0_out,
  output logic                  route_req_1_out,
  output logic                  tail_out,
  output logic                  yummy_out,
  output logic                  overflow_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_HEADER,
    ST_BODY
  } state_e;

  // FIFO storage and bookkeeping
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  // Packet tracking
  state_e                 state_q, state_d;
  logic [PAYLOAD_LEN-1:0] remaining_q, remaining_d;
  logic                   route_q, route_d;      // 1 selects port 1

  logic                   yummy_q, yummy_d;
  logic                   overflow_q, overflow_d;

  logic                   empty, full, push, pop;
  logic [DATA_WIDTH-1:0]  head;
  logic [PAYLOAD_LEN-1:0] hdr_len;
  logic                   route_dec;
  logic                   sel_route;
  logic                   is_header;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(FIFO_DEPTH));

  // A pop needs exactly one thanks and a head flit to consume. Simultaneous
  // thanks, or thanks with nothing buffered, are protocol errors and are
  // ignored here.
  assign pop  = (thanks_0_in ^ thanks_1_in) & ~empty;
  // When the FIFO is full, a push is accepted only if a pop frees a slot
  // in the same cycle.
  assign push = valid_in & (~full | pop);

  assign head      = mem_q[rd_ptr_q];
  assign hdr_len   = head[LEN_LSB +: PAYLOAD_LEN];
  assign route_dec = (head[DEST_LSB +: DEST_WIDTH] != my_addr);
  assign is_header = (state_q == ST_HEADER);

  // NOTE: every variable assigned here gets its default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    state_d     = state_q;
    remaining_d = remaining_q;
    route_d     = route_q;
    yummy_d     = pop;
    overflow_d  = overflow_q | (valid_in & full & ~pop);

    // Pointer widths equal log2(depth), so the increment wraps by itself.
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    if (pop) begin
      unique case (state_q)
        ST_HEADER: begin
          route_d = route_dec;
          if (hdr_len != '0) begin
            state_d     = ST_BODY;
            remaining_d = hdr_len;
          end
        end
        ST_BODY: begin
          remaining_d = remaining_q - PAYLOAD_LEN'(1);
          if (remaining_q == PAYLOAD_LEN'(1)) state_d = ST_HEADER;
        end
        default: state_d = ST_HEADER;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that every
  // register samples the pre-edge values, whatever the block order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= ST_HEADER;
      remaining_q <= '0;
      route_q     <= 1'b0;
      yummy_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      remaining_q <= remaining_d;
      route_q     <= route_d;
      yummy_q     <= yummy_d;
      overflow_q  <= overflow_d;
    end
  end

  // NOTE: the storage array has no reset. The count alone decides which
  // entries are meaningful, so clearing the data would only cost logic.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= data_in;
  end

  // The request comes from the live header decode while in HEADER and from
  // the latched route while in BODY. Both requests drop whenever the FIFO is
  // empty.
  assign sel_route       = is_header ? route_dec : route_q;
  assign data_out        = head;
  assign valid_out       = ~empty;
  assign route_req_0_out = valid_out & ~sel_route;
  assign route_req_1_out = valid_out &  sel_route;
  assign tail_out        = valid_out & (is_header ? (hdr_len == '0)
                                                  : (remaining_q == PAYLOAD_LEN'(1)));
  assign yummy_out       = yummy_q;
  assign overflow_err    = overflow_q;

endmodule

// File: tb/tb_dynamic_input_port_para.sv
// -----------------------------------------------------------------------------
// tb_dynamic_input_port_para
//
// Directed bench for dynamic_input_port_para. A queue-based packet model
// predicts every output on every cycle. Literal expectations at key points of
// each scenario pin the model itself.
// -----------------------------------------------------------------------------
module tb_dynamic_input_port_para;

  localparam int DW    = 64;
  localparam int DEPTH = 4;
  localparam int LLSB  = 22;
  localparam int PLEN  = 8;
  localparam int DLSB  = 30;
  localparam int DWID  = 22;

  localparam logic [DWID-1:0] MY    = 22'h12345;
  localparam logic [DWID-1:0] OTHER = 22'h0ABCD;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [DWID-1:0] my_addr = MY;
  logic [DW-1:0]   data_in = '0;
  logic            valid_in = 1'b0;
  logic            thanks_0_in = 1'b0;
  logic            thanks_1_in = 1'b0;
  logic [DW-1:0]   data_out;
  logic            valid_out, route_req_0_out, route_req_1_out;
  logic            tail_out, yummy_out, overflow_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;

  always #5 clk = ~clk;

  dynamic_input_port_para #(
    .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .LEN_LSB(LLSB),
    .PAYLOAD_LEN(PLEN), .DEST_LSB(DLSB), .DEST_WIDTH(DWID)
  ) dut (
    .clk(clk), .reset(reset), .my_addr(my_addr),
    .data_in(data_in), .valid_in(valid_in),
    .thanks_0_in(thanks_0_in), .thanks_1_in(thanks_1_in),
    .data_out(data_out), .valid_out(valid_out),
    .route_req_0_out(route_req_0_out), .route_req_1_out(route_req_1_out),
    .tail_out(tail_out), .yummy_out(yummy_out), .overflow_err(overflow_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] hdr(input logic [DWID-1:0] dest,
                                        input logic [PLEN-1:0] len,
                                        input logic [15:0] tag);
    logic [DW-1:0] h;
    h = '0;
    h[DLSB +: DWID] = dest;
    h[LLSB +: PLEN] = len;
    h[15:0]         = tag;
    return h;
  endfunction

  // ---------------------------------------------------------------- model
  logic [DW-1:0] mq[$];
  bit            m_body;
  int            m_rem;
  bit            m_route;     // 1 = port 1
  bit            m_yummy;
  bit            m_ovf;
  bit            m_pop;
  logic [DW-1:0] m_f;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_body  = 0;
      m_rem   = 0;
      m_route = 0;
      m_yummy = 0;
      m_ovf   = 0;
    end else begin
      m_pop   = (thanks_0_in != thanks_1_in) && (mq.size() > 0);
      m_yummy = m_pop;
      if (m_pop) begin
        m_f = mq.pop_front();
        if (!m_body) begin
          m_route = (m_f[DLSB +: DWID] != my_addr);
          if (int'(m_f[LLSB +: PLEN]) > 0) begin
            m_body = 1;
            m_rem  = int'(m_f[LLSB +: PLEN]);
          end
        end else begin
          m_rem--;
          if (m_rem == 0) m_body = 0;
        end
      end
      if (valid_in) begin
        if (mq.size() < DEPTH) mq.push_back(data_in);
        else m_ovf = 1;
      end
    end
  end

  // ------------------------------------------------------ compare process
  always @(negedge clk) begin
    bit e_valid, e_route, e_tail;
    if (started) begin
      e_valid = (mq.size() > 0);
      e_route = 0;
      e_tail  = 0;
      if (e_valid) begin
        if (!m_body) begin
          e_route = (mq[0][DLSB +: DWID] != my_addr);
          e_tail  = (mq[0][LLSB +: PLEN] == '0);
        end else begin
          e_route = m_route;
          e_tail  = (m_rem == 1);
        end
        check("data_out", data_out, mq[0]);
      end
      check("valid_out", valid_out, e_valid);
      check("route_req_0", route_req_0_out, e_valid & ~e_route);
      check("route_req_1", route_req_1_out, e_valid & e_route);
      check("tail_out", tail_out, e_tail);
      check("yummy_out", yummy_out, m_yummy);
      check("overflow_err", overflow_err, m_ovf);
      // Protocol guard: a thanks must target a non-empty FIFO, and only one
      // port may give thanks at a time.
      if (thanks_0_in || thanks_1_in)
        check("thanks_legal", {62'd0, valid_out, ~(thanks_0_in & thanks_1_in)}, 64'd3);
    end
  end

  // ------------------------------------------------------------- stimulus
  // Drive one cycle of inputs, let the edge consume them, then return 1 time
  // unit after the edge with the inputs back at idle.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic t0, input logic t1);
    valid_in    = v;
    data_in     = d;
    thanks_0_in = t0;
    thanks_1_in = t1;
    @(posedge clk);
    #1;
    valid_in    = 1'b0;
    thanks_0_in = 1'b0;
    thanks_1_in = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(0, '0, 0, 0);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    started = 1'b1;
    check("rst_valid", valid_out, 1'b0);
    check("rst_yummy", yummy_out, 1'b0);
    check("rst_ovf", overflow_err, 1'b0);
    check("rst_req", {route_req_1_out, route_req_0_out, tail_out}, 3'b000);

    // 1: local packet, len=2, back-to-back with thanks_0 from cycle 1
    cyc(1, hdr(MY, 8'd2, 16'hA001), 0, 0);
    check("t1_hdr_req0", route_req_0_out, 1'b1);
    check("t1_hdr_tail", tail_out, 1'b0);
    cyc(1, 64'hDEAD_BEEF_0000_0001, 1, 0);
    check("t1_y1", yummy_out, 1'b1);
    check("t1_b1_tail", tail_out, 1'b0);
    cyc(1, 64'hDEAD_BEEF_0000_0002, 1, 0);
    check("t1_b2_tail", tail_out, 1'b1);
    check("t1_b2_req0", route_req_0_out, 1'b1);
    cyc(0, '0, 1, 0);
    check("t1_empty", valid_out, 1'b0);
    check("t1_y3", yummy_out, 1'b1);
    cyc(0, '0, 0, 0);
    check("t1_noy", yummy_out, 1'b0);

    // 2: pass-through header with no payload
    cyc(1, hdr(OTHER, 8'd0, 16'hB001), 0, 0);
    check("t2_req", {route_req_1_out, route_req_0_out, tail_out}, 3'b101);
    cyc(0, '0, 0, 1);
    check("t2_empty", valid_out, 1'b0);
    check("t2_y", yummy_out, 1'b1);
    cyc(0, '0, 0, 0);

    // 3: fill, overflow, then full push with a simultaneous pop
    cyc(1, hdr(MY, 8'd3, 16'hC001), 0, 0);
    for (int i = 1; i < 4; i++) begin
      cyc(1, 64'h5555_0000_0000_0000 | 64'(i), 0, 0);
      check("t3_fill_valid", valid_out, 1'b1);
      check("t3_fill_noy", yummy_out, 1'b0);
    end
    check("t3_no_ovf", overflow_err, 1'b0);
    cyc(1, 64'hBAD0_BAD0_BAD0_BAD0, 0, 0);
    check("t3_ovf", overflow_err, 1'b1);
    check("t3_head_kept", data_out, hdr(MY, 8'd3, 16'hC001));
    cyc(1, hdr(OTHER, 8'd0, 16'hC005), 1, 0);
    check("t3_ovf_sticky", overflow_err, 1'b1);
    check("t3_pp_y", yummy_out, 1'b1);
    for (int i = 0; i < 4; i++) cyc(0, '0, 1, 0);
    check("t3_drained", valid_out, 1'b0);
    do_reset();
    check("t3_ovf_clr", overflow_err, 1'b0);

    // 4: pass-through packet, len=3, that starves mid-packet. The body flits
    // look like local headers, so a wrong resume would show up as port 0.
    cyc(1, hdr(OTHER, 8'd3, 16'hD001), 0, 0);
    cyc(1, hdr(MY, 8'd0, 16'hD002), 1, 0);
    cyc(0, '0, 1, 0);
    check("t4_starve", {valid_out, route_req_1_out, route_req_0_out}, 3'b000);
    for (int i = 0; i < 5; i++) cyc(0, '0, 0, 0);
    check("t4_idle", {route_req_1_out, route_req_0_out}, 2'b00);
    cyc(1, hdr(MY, 8'd0, 16'hD003), 0, 0);
    check("t4_resume", {route_req_1_out, route_req_0_out, tail_out}, 3'b100);
    cyc(1, hdr(MY, 8'd0, 16'hD004), 0, 1);
    check("t4_tail", {route_req_1_out, route_req_0_out, tail_out}, 3'b101);
    cyc(0, '0, 0, 1);
    check("t4_done", valid_out, 1'b0);

    // 5: two queued packets; the request switches ports after the tail pop
    cyc(1, hdr(MY, 8'd1, 16'hE001), 0, 0);
    cyc(1, 64'h7777_0000_0000_0002, 0, 0);
    cyc(1, hdr(OTHER, 8'd0, 16'hE003), 0, 0);
    check("t5_first", {route_req_1_out, route_req_0_out, tail_out}, 3'b010);
    cyc(0, '0, 1, 0);
    check("t5_body", {route_req_1_out, route_req_0_out, tail_out}, 3'b011);
    cyc(0, '0, 1, 0);
    check("t5_switch", {route_req_1_out, route_req_0_out, tail_out}, 3'b101);
    cyc(0, '0, 0, 1);
    check("t5_done", valid_out, 1'b0);

    // 6: reset mid-packet with 3 flits buffered
    cyc(1, hdr(MY, 8'd5, 16'hF001), 0, 0);
    cyc(1, 64'h9999_0000_0000_0001, 0, 0);
    cyc(1, 64'h9999_0000_0000_0002, 1, 0);
    cyc(1, 64'h9999_0000_0000_0003, 0, 0);
    check("t6_buffered", valid_out, 1'b1);
    reset = 1'b1;
    cyc(0, '0, 0, 0);
    reset = 1'b0;
    check("t6_rst_valid", valid_out, 1'b0);
    check("t6_rst_noy", yummy_out, 1'b0);
    cyc(0, '0, 0, 0);
    check("t6_noy2", yummy_out, 1'b0);
    cyc(1, hdr(OTHER, 8'd0, 16'hF005), 0, 0);
    check("t6_new_hdr", {route_req_1_out, route_req_0_out, tail_out}, 3'b101);
    cyc(0, '0, 0, 1);
    cyc(0, '0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
